uart_tx_fifo: RTL
=================

// Module: uart_tx_fifo
// PURPOSE
//   Parametrised UART transmitter with an integrated TX FIFO. Next generation of the single-byte TX:
//   configurable data width, stop bits and buffer depth; optional parity.
//   Sits between CPU/bus-side byte producers and the board serial pin.
//   Frames are sent back-to-back with no idle gap while the FIFO holds data.
// PARAMETERS
//   CLK_FREQ    27      clock frequency in MHz
//   BAUD        115200  serial baud rate; CYCLE = CLK_FREQ*1000000/BAUD clocks per bit (CYCLE >= 2)
//   DATA_BITS   8       data bits per frame, legal 5..8
//   STOP_BITS   1       stop bits, legal 1 or 2
//   FIFO_DEPTH  16      FIFO entries, power of two, >= 2
// PORTS
//   clk         in   1                          system clock
//   rst         in   1                          synchronous reset, active-high
//   data        in   DATA_BITS                  byte to enqueue
//   valid       in   1                          data valid; push when valid && ready
//   ready       out  1                          FIFO can accept (not full)
//   parity_odd  in   1                          1 = odd parity, 0 = even; ignored without UART_TX_PARITY_EN
//   tx          out  1                          serial output, idle high
//   busy        out  1                          frame in progress (state != IDLE)
//   fifo_level  out  $clog2(FIFO_DEPTH)+1       entries currently queued
// BEHAVIOUR
//   - One clock; rst is synchronous and active-high. All state updates on posedge clk.
//   - Reset values: tx=1, ready=0, busy=0, fifo_level=0. FIFO flushed, state=IDLE, counters=0.
//     ready rises on the first edge after rst deasserts. Reset mid-frame aborts: tx=1 on the next edge.
//   - ready is registered: 1 iff level < FIFO_DEPTH after this edge's push/pop.
//     valid while ready=0 is ignored (no push, no error).
//   - Push and pop in the same cycle are allowed: level unchanged, data order preserved.
//   - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> (START | IDLE).
//     - IDLE: if level != 0, pop head into shift latch, go START. Else stay.
//     - START: tx=0 for CYCLE clocks.
//     - DATA: DATA_BITS bits, LSB first, CYCLE clocks each; bit counter 0..DATA_BITS-1.
//     - PARITY: present only with the macro; one bit, CYCLE clocks.
//     - STOP: tx=1 for STOP_BITS*CYCLE clocks. On the final clock, if level != 0, pop and go
//       straight to START (no idle bit). Otherwise go IDLE.
//   - Latency: push into empty FIFO while IDLE -> tx falls exactly 2 clocks after the accepting edge.
//   - tx is registered from the current state and bit. Frame length is
//     (1 + DATA_BITS + P + STOP_BITS)*CYCLE clocks, where P = 1 if parity is compiled in, else 0.
//   - Baud counter: 16-bit. Clears on every bit boundary and state change.
//     Wrap is never reached; CYCLE must fit in 16 bits.
//   - fifo_level saturates structurally at FIFO_DEPTH. Read/write pointers wrap modulo FIFO_DEPTH.
//   - busy=1 from the START entry edge until the edge returning to IDLE.
// CONFIGURATION
//   UART_TX_PARITY_EN defined:
//     - PARITY state inserted after DATA.
//     - Parity bit = ^data_latch ^ parity_odd. parity_odd is sampled at pop time and held for the frame.
//   UART_TX_PARITY_EN undefined:
//     - No PARITY state; STOP follows DATA directly. parity_odd is unused.
//     - Port list is identical in both builds.
// TESTING
//   1. CLK_FREQ=1, BAUD=250000 (CYCLE=4), 8N1; push 0x55 -> tx: 4 clk low, then 1,0,1,0,1,0,1,0 LSB first,
//      4 clk each, then 4 clk high. busy high 40 clk.
//   2. FIFO_DEPTH=4; push 0x01..0x05 on consecutive clocks -> 0x01 popped at once, 0x02..0x05 fill FIFO.
//      ready=0 after the 5th push. Frames 0x01..0x05 sent back-to-back, no idle bit between stop and start.
//   3. valid held with ready=0 carrying 0xAA -> 0xAA never transmitted. fifo_level stays 4.
//   4. UART_TX_PARITY_EN defined, parity_odd=0; send 0x07 -> parity bit 1. parity_odd=1 -> parity bit 0.
//      Frame = 11*CYCLE clocks.
//   5. STOP_BITS=2, DATA_BITS=7; send 0x7F -> 7 data bits high, then stop high for 8 clk (CYCLE=4).
//      Next frame start no earlier.
//   6. Assert rst for 1 clk mid-DATA with 3 entries queued -> next edge tx=1, busy=0, fifo_level=0, ready=0.
//      ready=1 one edge later. Nothing further sent.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter. Frames are sent back-to-back while the FIFO holds data.
// Optional parity bit when UART_TX_PARITY_EN is defined. The port list is the same in both builds.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   data       word to enqueue (DATA_BITS wide)
//   valid      push request, accepted when valid && ready
//   ready      FIFO not full (registered)
//   parity_odd 1 = odd parity, 0 = even (used only with UART_TX_PARITY_EN)
//   tx         serial line, idle high
//   busy       frame in progress
//   fifo_level entries queued
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 27,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          data,
  input  logic                          valid,
  output logic                          ready,
  input  logic                          parity_odd,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CYCLE = CLK_FREQ * 1000000 / BAUD;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;

  localparam logic [15:0] BIT_END  = 16'(CYCLE - 1);
  localparam logic [15:0] STOP_END = 16'(STOP_BITS * CYCLE - 1);
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state, state_n;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wptr, rptr;
  logic [LW-1:0]        level, level_n;
  logic                 push, pop;
  logic [DATA_BITS-1:0] shreg;
  logic [15:0]          cnt;
  logic [2:0]           bit_idx;
  logic                 bit_end;
  logic                 tx_n;

`ifdef UART_TX_PARITY_EN
  logic par_odd;
`else
  logic unused_parity;
  assign unused_parity = parity_odd;
`endif

  assign push       = valid && ready;
  assign busy       = (state != IDLE);
  assign fifo_level = level;
  assign bit_end    = (cnt == BIT_END);
  assign level_n    = level + LW'(push) - LW'(pop);

  // FIFO storage, no reset needed on the array
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      ready <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      level <= level_n;
      ready <= (level_n < LW'(FIFO_DEPTH));
    end
  end

  // Head word and its parity mode are frozen for the whole frame
  always_ff @(posedge clk) begin
    if (pop) begin
      shreg   <= mem[rptr];
`ifdef UART_TX_PARITY_EN
      par_odd <= parity_odd;
`endif
    end
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (level != '0) begin
          pop     = 1'b1;
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
        end
      end
      DATA: begin
        if (bit_end && bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        // Chain straight into the next start bit when data is waiting
        if (cnt == STOP_END) begin
          if (level != '0) begin
            pop     = 1'b1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_comb begin
    tx_n = 1'b1;
    unique case (state)
      START:  tx_n = 1'b0;
      DATA:   tx_n = shreg[bit_idx];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_n = ^shreg ^ par_odd;
`endif
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
    end else begin
      state <= state_n;
      tx    <= tx_n;
      if (state_n != state || state == IDLE ||
          (state == DATA && bit_end)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 16'd1;
      end
      if (state != DATA) begin
        bit_idx <= '0;
      end else if (bit_end) begin
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

endmodule
